// File: rtl/door_fsm_timed.sv
`default_nettype none
// ============================================================================
// Module      : door_fsm_timed
// Description : Automatic door controller with debounced presence input,
//               hold/motion timers, emergency stop and latched fault state.
// Revision    : 1.0 - initial release
// ============================================================================
module door_fsm_timed #(
    parameter int CNT_W        = 16,
    parameter int HOLD_CYCLES  = 1000,
    parameter int MOVE_TIMEOUT = 5000,
    parameter int DEB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       sen,
    input  logic       stop,
    input  logic       la,
    input  logic       lc,
    input  logic       fault_clr,
    output logic       motor_open,
    output logic       motor_close,
    output logic [2:0] state_o,
    output logic       fault
);

    // Parameter legality: timer compare values must be representable in CNT_W bits.
    generate
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("door_fsm_timed: CNT_W must be >= 1");
        end
        if (HOLD_CYCLES < 1 ||
            (CNT_W < 32 && longint'(HOLD_CYCLES) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_hold
            $error("door_fsm_timed: HOLD_CYCLES out of range 1..2^CNT_W-1");
        end
        if (MOVE_TIMEOUT < 1 ||
            (CNT_W < 32 && longint'(MOVE_TIMEOUT) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_move
            $error("door_fsm_timed: MOVE_TIMEOUT out of range 1..2^CNT_W-1");
        end
        if (DEB_CYCLES < 1) begin : g_bad_deb
            $error("door_fsm_timed: DEB_CYCLES must be >= 1");
        end
    endgenerate

    localparam int               c_DEB_W      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_MOVE_LAST  = CNT_W'(MOVE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_TIMER_SAT  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_CLOSED  = 3'd0,
        S_OPENING = 3'd1,
        S_OPEN    = 3'd2,
        S_CLOSING = 3'd3,
        S_ESTOP   = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_timer;
    logic [CNT_W-1:0]     w_timer_nxt;
    logic                 r_sen_deb;
    logic                 w_sen_deb_nxt;
    logic [c_DEB_W-1:0]   r_deb_cnt;
    logic [c_DEB_W-1:0]   w_deb_cnt_nxt;
    logic                 w_illegal;
    logic                 w_move_expired;

    // Codes 6 and 7 are the only encodings with both upper bits set.
    assign w_illegal      = r_state[2] & r_state[1];
    assign w_move_expired = (r_timer == c_MOVE_LAST);

    // Debouncer: count consecutive enabled cycles where sen disagrees with the
    // filtered value; any agreeing cycle restarts the count.
    always_comb begin
        w_sen_deb_nxt = r_sen_deb;
        w_deb_cnt_nxt = '0;
        if (sen != r_sen_deb) begin
            if (r_deb_cnt == c_DEB_LAST) begin
                w_sen_deb_nxt = sen;
            end else begin
                w_deb_cnt_nxt = r_deb_cnt + c_DEB_W'(1);
            end
        end
    end

    // Next state: stop first, then limit switch conflict, then per-state rules.
    always_comb begin
        w_state_nxt = r_state;
        if (w_illegal) begin
            w_state_nxt = S_FAULT;
        end else if (stop && (r_state != S_FAULT)) begin
            w_state_nxt = S_ESTOP;
        end else if (la && lc && (r_state != S_ESTOP) && (r_state != S_FAULT)) begin
            w_state_nxt = S_FAULT;
        end else begin
            case (r_state)
                S_CLOSED: begin
                    if (r_sen_deb) begin
                        w_state_nxt = S_OPENING;
                    end else if (!lc) begin
                        w_state_nxt = S_CLOSING;
                    end
                end
                S_OPENING: begin
                    if (la) begin
                        w_state_nxt = S_OPEN;
                    end else if (w_move_expired) begin
                        w_state_nxt = S_FAULT;
                    end
                end
                S_OPEN: begin
                    if (!r_sen_deb && (r_timer == c_HOLD_LAST)) begin
                        w_state_nxt = S_CLOSING;
                    end
                end
                S_CLOSING: begin
                    // Reaching the closed limit wins over a late reversal request.
                    if (lc) begin
                        w_state_nxt = S_CLOSED;
                    end else if (r_sen_deb) begin
                        w_state_nxt = S_OPENING;
                    end else if (w_move_expired) begin
                        w_state_nxt = S_FAULT;
                    end
                end
                S_ESTOP: begin
                    w_state_nxt = lc ? S_CLOSED : S_OPENING;
                end
                S_FAULT: begin
                    if (fault_clr && !stop) begin
                        w_state_nxt = S_CLOSED;
                    end
                end
                default: begin
                    w_state_nxt = S_FAULT;
                end
            endcase
        end
    end

    // Time-in-state counter; presence in OPEN keeps restarting the hold period.
    always_comb begin
        w_timer_nxt = r_timer;
        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
        end else if ((r_state == S_OPEN) && r_sen_deb) begin
            w_timer_nxt = '0;
        end else if (r_timer != c_TIMER_SAT) begin
            w_timer_nxt = r_timer + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLOSED;
            r_timer   <= '0;
            r_sen_deb <= 1'b0;
            r_deb_cnt <= '0;
        end else if (ena) begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_sen_deb <= w_sen_deb_nxt;
            r_deb_cnt <= w_deb_cnt_nxt;
        end
    end

    assign motor_open  = (r_state == S_OPENING);
    assign motor_close = (r_state == S_CLOSING);
    assign fault       = (r_state == S_FAULT);
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: doc/door_fsm_timed.md
DOOR_FSM_TIMED -- requirements
Module: door_fsm_timed

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the state timer.
REQ-002 SHALL have parameter HOLD_CYCLES, default 1000, number of enabled cycles the door stays open after presence clears.
REQ-003 SHALL have parameter MOVE_TIMEOUT, default 5000, maximum number of enabled cycles allowed in a motion state.
REQ-004 SHALL have parameter DEB_CYCLES, default 4, number of stable enabled cycles needed to debounce sen.
REQ-005 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port ena, input, 1 bit: clock enable; when low, state, timer and debouncer are held.
REQ-008 SHALL have port sen, input, 1 bit: presence/open request, raw.
REQ-009 SHALL have port stop, input, 1 bit: emergency stop, level, not debounced.
REQ-010 SHALL have port la, input, 1 bit: open limit switch.
REQ-011 SHALL have port lc, input, 1 bit: closed limit switch.
REQ-012 SHALL have port fault_clr, input, 1 bit: fault acknowledge.
REQ-013 SHALL have outputs motor_open and motor_close, 1 bit each: motor drive.
REQ-014 SHALL have output state_o, 3 bits: current state code.
REQ-015 SHALL have output fault, 1 bit: high while in FAULT.

Function
REQ-016 SHALL use state codes CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, ESTOP=4, FAULT=5; codes 6 and 7 SHALL go to FAULT on the next enabled cycle.
REQ-017 SHALL decode outputs from the registered state only: motor_open=(OPENING), motor_close=(CLOSING), fault=(FAULT); motor_open and motor_close SHALL never both be 1.
REQ-018 SHALL change sen_deb only after sen holds the opposite value for DEB_CYCLES consecutive enabled cycles; any toggle SHALL restart the count.
REQ-019 SHALL clear the timer to 0 on every state change and increment it on every other enabled cycle, saturating at 2^CNT_W-1.
REQ-020 SHALL apply transitions in priority order: stop, la&lc conflict, then per-state rules.
REQ-021 SHALL go from any state except FAULT to ESTOP when stop=1.
REQ-022 SHALL go from any state except ESTOP and FAULT to FAULT when la=1 and lc=1.
REQ-023 In CLOSED, SHALL go to OPENING if sen_deb=1, else to CLOSING if lc=0.
REQ-024 In OPENING, SHALL go to OPEN if la=1, else to FAULT when timer==MOVE_TIMEOUT-1.
REQ-025 In OPEN, SHALL reload timer to 0 while sen_deb=1, and go to CLOSING when timer==HOLD_CYCLES-1 and sen_deb=0.
REQ-026 In CLOSING, SHALL go to CLOSED if lc=1, else to OPENING if sen_deb=1 (reversal, lc takes priority), else to FAULT when timer==MOVE_TIMEOUT-1.
REQ-027 In ESTOP, when stop=0, SHALL go to CLOSED if lc=1, else to OPENING.
REQ-028 In FAULT, SHALL go to CLOSED when fault_clr=1 and stop=0; stop SHALL NOT leave FAULT.
REQ-029 SHALL accept HOLD_CYCLES and MOVE_TIMEOUT only in range 1..2^CNT_W-1, and DEB_CYCLES only >=1; elaboration SHALL fail otherwise.

Reset
REQ-030 SHALL on rst_n=0, immediately and independent of clk, set state=CLOSED, timer=0, sen_deb=0, debounce count=0, so motor_open=0, motor_close=0, fault=0, state_o=0.
REQ-031 SHALL abort motion when reset is asserted mid-OPENING/CLOSING, with motors off in the same cycle.

Verification (HOLD_CYCLES=8, MOVE_TIMEOUT=20, DEB_CYCLES=2)
REQ-032 SHALL cover the full cycle: lc=1, sen=1 for 2 cycles -> OPENING, motor_open=1; la=1 -> OPEN; sen=0 held -> CLOSING 8 cycles after sen_deb falls; lc=1 -> CLOSED, state_o=0.
REQ-033 SHALL cover reversal: sen_deb rises in CLOSING with lc=0 -> next state OPENING, motor_close 1->0 and motor_open 0->1, never both 1.
REQ-034 SHALL cover timeout: OPENING with la=0 for 20 cycles -> FAULT, fault=1, motors 0; fault_clr=1 with stop=0 -> CLOSED.
REQ-035 SHALL cover estop: stop=1 in OPEN -> ESTOP, motors 0; stop=0 with lc=0 -> OPENING; stop=1 in FAULT -> stays FAULT.
REQ-036 SHALL cover glitch/enable: 1-cycle sen pulse -> no state change; ena=0 for 10 cycles in OPEN -> timer and state frozen.
REQ-037 SHALL cover async reset in CLOSING -> motor_close=0 before the next clk edge, state_o=0.
